// File: rtl/ct_lsu_dcache_tagdirty_arb_if.sv
// Tag/dirty array write-port bundle: three requesters (linefill, snoop, set&way) plus the array write side.
// Latency: none (signal bundle only).
// Backpressure: requesters hold req and payload until their grnt; stall blocks all grants.
interface ct_lsu_dcache_tagdirty_arb_if;
   logic        dcache_arb_stall;
   logic        rfl_req;
   logic        rfl_grnt;
   logic [8:0]  rfl_idx;
   logic [51:0] rfl_tag_din;
   logic [1:0]  rfl_tag_wen;
   logic [6:0]  rfl_dirty_din;
   logic [6:0]  rfl_dirty_wen;
   logic        snq_req;
   logic        snq_grnt;
   logic [8:0]  snq_idx;
   logic [6:0]  snq_dirty_din;
   logic [6:0]  snq_dirty_wen;
   logic        icc_req;
   logic        icc_grnt;
   logic [8:0]  icc_idx;
   logic [6:0]  icc_dirty_din;
   logic [6:0]  icc_dirty_wen;
   logic [8:0]  dcache_idx;
   logic        dcache_tag_gwen;
   logic [1:0]  dcache_tag_wen;
   logic [51:0] dcache_tag_din;
   logic        dcache_dirty_gwen;
   logic [6:0]  dcache_dirty_wen;
   logic [6:0]  dcache_dirty_din;
   logic        dcache_sw_inst;

   // arbiter side
   modport slave (
      input  dcache_arb_stall,
      input  rfl_req, rfl_idx, rfl_tag_din, rfl_tag_wen, rfl_dirty_din, rfl_dirty_wen,
      output rfl_grnt,
      input  snq_req, snq_idx, snq_dirty_din, snq_dirty_wen,
      output snq_grnt,
      input  icc_req, icc_idx, icc_dirty_din, icc_dirty_wen,
      output icc_grnt,
      output dcache_idx, dcache_tag_gwen, dcache_tag_wen, dcache_tag_din,
      output dcache_dirty_gwen, dcache_dirty_wen, dcache_dirty_din, dcache_sw_inst
   );

   // requester / environment side
   modport master (
      output dcache_arb_stall,
      output rfl_req, rfl_idx, rfl_tag_din, rfl_tag_wen, rfl_dirty_din, rfl_dirty_wen,
      input  rfl_grnt,
      output snq_req, snq_idx, snq_dirty_din, snq_dirty_wen,
      input  snq_grnt,
      output icc_req, icc_idx, icc_dirty_din, icc_dirty_wen,
      input  icc_grnt,
      input  dcache_idx, dcache_tag_gwen, dcache_tag_wen, dcache_tag_din,
      input  dcache_dirty_gwen, dcache_dirty_wen, dcache_dirty_din, dcache_sw_inst
   );
endinterface

// File: rtl/ct_lsu_dcache_tagdirty_arb.sv
// Arbitrates linefill / snoop / set&way writes onto the dcache tag+dirty arrays (optional starvation promotion: LSU_DCACHE_ARB_STARVE_EN).
// Latency: grant combinational in cycle N, registered single-cycle array write pulse in N+1.
// Backpressure: dcache_arb_stall or cpurst blocks every grant; a grant already given is always written.
module ct_lsu_dcache_tagdirty_arb #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic                       forever_cpuclk,
   input logic                       cpurst,
   ct_lsu_dcache_tagdirty_arb_if.slave arb
);

   typedef struct packed {
      logic [8:0]  idx;
      logic        tag_gwen;
      logic [1:0]  tag_wen;
      logic [51:0] tag_din;
      logic        dirty_gwen;
      logic [6:0]  dirty_wen;
      logic [6:0]  dirty_din;
      logic        sw_inst;
   } wr_t;

   // Counters are 4 bits wide and must be able to count at least twice before promotion.
   if (STARVE_LIMIT < 2 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
      $error("STARVE_LIMIT out of range 2..15");
   end

   logic arb_ok;
   logic snq_win;
   logic rfl_win;
   logic icc_win;
   logic snq_grnt;
   logic rfl_grnt;
   logic icc_grnt;
   wr_t  wr_nxt;
   wr_t  wr_q;

   assign arb_ok = !arb.dcache_arb_stall && !cpurst;

`ifdef LSU_DCACHE_ARB_STARVE_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] snq_cnt;
   logic [3:0] rfl_cnt;
   logic [3:0] icc_cnt;
   logic       snq_starved;
   logic       rfl_starved;
   logic       icc_starved;

   // Waiting cycles only accrue while the array was actually available to someone.
   function automatic logic [3:0] cnt_nxt(input logic req, input logic grnt,
                                          input logic stall, input logic [3:0] cnt);
      logic [3:0] n;
      n = cnt;
      if (!req || grnt)
         n = 4'd0;
      else if (!stall && cnt != LIMIT)
         n = cnt + 4'd1;
      return n;
   endfunction

   assign snq_starved = arb.snq_req && (snq_cnt == LIMIT);
   assign rfl_starved = arb.rfl_req && (rfl_cnt == LIMIT);
   assign icc_starved = arb.icc_req && (icc_cnt == LIMIT);

   // Starved requesters pre-empt everyone else; base order snq > rfl > icc inside each class.
   always_comb begin
      snq_win = 1'b0;
      rfl_win = 1'b0;
      icc_win = 1'b0;
      if (snq_starved || rfl_starved || icc_starved) begin
         snq_win = snq_starved;
         rfl_win = rfl_starved && !snq_starved;
         icc_win = icc_starved && !snq_starved && !rfl_starved;
      end else begin
         snq_win = arb.snq_req;
         rfl_win = arb.rfl_req && !arb.snq_req;
         icc_win = arb.icc_req && !arb.snq_req && !arb.rfl_req;
      end
   end

   // Per-requester starvation counters.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         snq_cnt <= 4'd0;
         rfl_cnt <= 4'd0;
         icc_cnt <= 4'd0;
      end else begin
         snq_cnt <= cnt_nxt(arb.snq_req, snq_grnt, arb.dcache_arb_stall, snq_cnt);
         rfl_cnt <= cnt_nxt(arb.rfl_req, rfl_grnt, arb.dcache_arb_stall, rfl_cnt);
         icc_cnt <= cnt_nxt(arb.icc_req, icc_grnt, arb.dcache_arb_stall, icc_cnt);
      end
   end
`else
   // Pure fixed priority snq > rfl > icc.
   always_comb begin
      snq_win = arb.snq_req;
      rfl_win = arb.rfl_req && !arb.snq_req;
      icc_win = arb.icc_req && !arb.snq_req && !arb.rfl_req;
   end
`endif

   assign snq_grnt = snq_win && arb_ok;
   assign rfl_grnt = rfl_win && arb_ok;
   assign icc_grnt = icc_win && arb_ok;

   assign arb.snq_grnt = snq_grnt;
   assign arb.rfl_grnt = rfl_grnt;
   assign arb.icc_grnt = icc_grnt;

   // Build next-cycle array write from the winner's payload; idle cycles write all zeros.
   always_comb begin
      wr_nxt = '0;
      if (rfl_grnt) begin
         wr_nxt.idx        = arb.rfl_idx;
         wr_nxt.tag_gwen   = 1'b1;
         wr_nxt.tag_wen    = arb.rfl_tag_wen;
         wr_nxt.tag_din    = arb.rfl_tag_din;
         wr_nxt.dirty_gwen = 1'b1;
         wr_nxt.dirty_wen  = arb.rfl_dirty_wen;
         wr_nxt.dirty_din  = arb.rfl_dirty_din;
      end else if (snq_grnt) begin
         wr_nxt.idx        = arb.snq_idx;
         wr_nxt.dirty_gwen = 1'b1;
         wr_nxt.dirty_wen  = arb.snq_dirty_wen;
         wr_nxt.dirty_din  = arb.snq_dirty_din;
      end else if (icc_grnt) begin
         wr_nxt.idx        = arb.icc_idx;
         wr_nxt.dirty_gwen = 1'b1;
         wr_nxt.dirty_wen  = arb.icc_dirty_wen;
         wr_nxt.dirty_din  = arb.icc_dirty_din;
         wr_nxt.sw_inst    = 1'b1;
      end
   end

   // Registered write pulse; stall does not gate it so an issued grant is never lost.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst)
         wr_q <= '0;
      else
         wr_q <= wr_nxt;
   end

   assign arb.dcache_idx        = wr_q.idx;
   assign arb.dcache_tag_gwen   = wr_q.tag_gwen;
   assign arb.dcache_tag_wen    = wr_q.tag_wen;
   assign arb.dcache_tag_din    = wr_q.tag_din;
   assign arb.dcache_dirty_gwen = wr_q.dirty_gwen;
   assign arb.dcache_dirty_wen  = wr_q.dirty_wen;
   assign arb.dcache_dirty_din  = wr_q.dirty_din;
   assign arb.dcache_sw_inst    = wr_q.sw_inst;

endmodule
